// File: rtl/rom_req_arbiter.sv
// Round-robin arbiter that serialises level-held ROM client reads onto one SDRAM read port
// and routes each returned word back to the requesting client as a one-cycle valid pulse.
module rom_req_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            cl_req,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] cl_addr,
  output logic [CHANNELS-1:0]            cl_valid,
  output logic [DATA_WIDTH-1:0]          cl_data,
  output logic                           sdram_req,
  output logic [ADDR_WIDTH-1:0]          sdram_addr,
  input  logic [DATA_WIDTH-1:0]          sdram_data,
  input  logic                           sdram_valid,
  output logic                           busy
);

  localparam int PTR_W = $clog2(CHANNELS);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                state, state_nx;
  ptr_t                  ptr, ptr_nx;
  ptr_t                  gnt, gnt_nx;
  logic [CHANNELS-1:0]   blk, blk_nx;
  logic                  sdram_req_nx;
  logic [ADDR_WIDTH-1:0] sdram_addr_nx;
  logic [CHANNELS-1:0]   cl_valid_nx;
  logic [DATA_WIDTH-1:0] cl_data_nx;
  logic                  busy_nx;

  logic [ADDR_WIDTH-1:0] addr_arr [CHANNELS];
  logic [CHANNELS-1:0]   eligible;
  logic                  found;
  ptr_t                  pick;
  logic [PTR_W:0]        cand;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_addr
    assign addr_arr[i] = cl_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Search starts at ptr and wraps by explicit compare so non-power-of-two CHANNELS work.
  always_comb begin
    eligible = cl_req & ~blk;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(CHANNELS)) cand = cand - (PTR_W+1)'(CHANNELS);
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[PTR_W-1:0];
      end
    end
  end

  // NOTE: every signal gets its default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    gnt_nx        = gnt;
    blk_nx        = '0;
    sdram_req_nx  = sdram_req;
    sdram_addr_nx = sdram_addr;
    cl_valid_nx   = '0;
    cl_data_nx    = cl_data;
    busy_nx       = busy;
    case (state)
      ST_IDLE: begin
        if (found) begin
          gnt_nx        = pick;
          sdram_addr_nx = addr_arr[pick];
          sdram_req_nx  = 1'b1;
          busy_nx       = 1'b1;
          state_nx      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_valid) begin
          sdram_req_nx     = 1'b0;
          cl_data_nx       = sdram_data;
          cl_valid_nx[gnt] = 1'b1;
          // The finished client still holds req for one cycle; mask it for exactly that cycle.
          blk_nx[gnt]      = 1'b1;
          ptr_nx           = (gnt == ptr_t'(CHANNELS-1)) ? '0 : gnt + ptr_t'(1);
          busy_nx          = 1'b0;
          state_nx         = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gnt        <= '0;
      blk        <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      cl_valid   <= '0;
      cl_data    <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      gnt        <= gnt_nx;
      blk        <= blk_nx;
      sdram_req  <= sdram_req_nx;
      sdram_addr <= sdram_addr_nx;
      cl_valid   <= cl_valid_nx;
      cl_data    <= cl_data_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: doc/rom_req_arbiter.md
Name: rom_req_arbiter

Overview:
- Round-robin arbiter between several read-only ROM clients (instruction/data caches, sprite/tile fetchers) and the single SDRAM read port.
- Each client uses the level-held req/addr, pulsed-valid protocol that the cache uses on its rom_req/rom_addr/rom_valid side.
- The arbiter serialises these requests onto one SDRAM read channel and routes the returned word back to the requesting client.
- It sits directly downstream of the caches and upstream of the SDRAM controller.

Parameters:
CHANNELS, 4, number of client channels (2..8)
ADDR_WIDTH, 23, word address width per client
DATA_WIDTH, 16, data word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cl_req  in  CHANNELS  per-client request; held high until that client's cl_valid is seen
cl_addr  in  CHANNELS*ADDR_WIDTH  packed client addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]; stable while cl_req[i]=1
cl_valid  out  CHANNELS  one-cycle pulse per completed read; at most one bit set per cycle
cl_data  out  DATA_WIDTH  read data, shared by all clients; valid when any cl_valid bit is high
sdram_req  out  1  read request, held high until sdram_valid
sdram_addr  out  ADDR_WIDTH  read address, stable while sdram_req=1
sdram_data  in  DATA_WIDTH  SDRAM read data
sdram_valid  in  1  one-cycle pulse: sdram_data valid, request complete
busy  out  1  high from grant until the cl_valid pulse

Behaviour:
Reset:
- sdram_req=0, sdram_addr=0, cl_valid=0, cl_data=0, busy=0.
- Round-robin pointer=0, state=IDLE, block mask cleared.
- Reset mid-transaction abandons it: no cl_valid is issued, and any sdram_valid in the reset cycle is ignored.

State machine:
- IDLE:
  - Eligible set = cl_req & ~blk.
  - If non-empty, pick the first eligible channel starting at ptr, wrapping CHANNELS-1 -> 0.
  - Latch gnt, set sdram_addr = cl_addr[gnt], sdram_req <= 1, busy <= 1, go to WAIT.
  - Latency: cl_req high at edge N -> sdram_req high after edge N.
- WAIT:
  - Hold sdram_req and sdram_addr.
  - On sdram_valid: sdram_req <= 0, cl_data <= sdram_data, cl_valid[gnt] <= 1.
  - Also set blk[gnt] <= 1, ptr <= (gnt+1) mod CHANNELS, busy <= 0, go to IDLE.
  - Data reaches the client one cycle after sdram_valid.
- Client request changes during WAIT are ignored, because clients must hold req and addr.

Block mask:
- A client drops req one cycle after it sees cl_valid, so its req is still high in the cycle cl_valid is asserted.
- blk[i] suppresses re-grant of channel i for exactly that cycle.
- blk clears on the next edge regardless of anything else.
- The first IDLE cycle after completion can therefore grant only other channels. Channel i becomes grantable again the following cycle.

Pipelining and timing:
- No pipelining: one outstanding SDRAM read.
- Minimum gap between completions is 2 cycles plus SDRAM latency.
- cl_valid is a registered pulse and is cleared every cycle unless set.

Protocol errors:
- sdram_valid while in IDLE is ignored; no cl_valid is produced.
- A client dropping cl_req during WAIT still receives its cl_valid.

Fairness:
- A continuously requesting client waits at most CHANNELS-1 other transactions.

Width rules:
- Pointer width is clog2(CHANNELS).
- Pointer wrap is an explicit compare, not power-of-two truncation.

Test Plan:
1. Single client: cl_req[0]=1, addr 0x012345; SDRAM returns 0xBEEF after 5 cycles.
   -> sdram_req rises 1 cycle after cl_req with sdram_addr=0x012345.
   -> cl_valid=4'b0001 with cl_data=0xBEEF 1 cycle after sdram_valid.
   -> sdram_req low in the same cycle cl_valid is high.
2. All four clients request simultaneously, addrs 0x10/0x20/0x30/0x40 -> grants in order 0,1,2,3 with matching sdram_addr; each gets exactly one cl_valid with the word returned for its address.
3. Client 1 holds req for back-to-back reads (next req 1 cycle after its valid) while client 2 requests continuously -> grants alternate 1,2,1,2; client 1 is never granted in its valid cycle.
4. Pointer wrap: ptr=3, requests on channels 0 and 3 -> channel 3 first, then 0.
5. Reset asserted in WAIT with sdram_valid in the same cycle -> no cl_valid; sdram_req=0 next cycle; ptr=0; a subsequent request on channel 2 issues normally.
6. Spurious sdram_valid in IDLE with no requests -> cl_valid stays 0; cl_data unchanged; state stays IDLE.
